alu_issue_ctrl: RTL and testbench

//  Issue-side driver for the 32-bit ALU. Accepts one RISC-V instruction plus

---
 rtl/alu_issue_if.sv | 32 +++
 rtl/alu_issue_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Handshake and ALU-side bundle for the ALU issue controller.
// The "slave" modport is the issue controller; "master" is its environment
// (decode/regfile upstream, ALU and writeback downstream).
interface alu_issue_if;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] insn_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic [31:0] alu_result_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [31:0] res_data_o;
  logic [4:0]  res_rd_o;
  logic        res_we_o;
  logic        illegal_o;

  modport slave (
    input  valid_i, insn_i, rs1_data_i, rs2_data_i, alu_result_i, res_ready_i,
    output ready_o, alu_ctrl_o, alu_a_o, alu_b_o, res_valid_o, res_data_o,
           res_rd_o, res_we_o, illegal_o
  );

  modport master (
    output valid_i, insn_i, rs1_data_i, rs2_data_i, alu_result_i, res_ready_i,
    input  ready_o, alu_ctrl_o, alu_a_o, alu_b_o, res_valid_o, res_data_o,
           res_rd_o, res_we_o, illegal_o
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue-side ALU driver: decodes one instruction, holds ALU operands for the
// op's execution time (1 cycle, MUL_LAT for MUL), captures the ALU result and
// returns it over a valid/ready handshake. Illegal instructions skip EXEC.
module alu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input logic       clk_i,
  input logic       rst_i,
  alu_issue_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] MUL_CNT   = MUL_LAT[3:0];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [3:0]  alu_ctrl_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic [31:0] res_data_q;
  logic [4:0]  res_rd_q;
  logic        res_we_q, illegal_q;

  logic [6:0]  opcode_s, funct7_s;
  logic [2:0]  funct3_s;
  logic        accept_s, last_exec_s;
  logic        dec_legal_s, dec_mul_s, dec_we_s;
  logic [3:0]  dec_ctrl_s;
  logic [31:0] dec_b_s;
  logic [4:0]  dec_rd_s;
  logic        unused_rs1_field_s;

  // Sign-extend a 12-bit immediate to 32 bits.
  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

  assign opcode_s    = bus.insn_i[6:0];
  assign funct3_s    = bus.insn_i[14:12];
  assign funct7_s    = bus.insn_i[31:25];
  // The rs1 field is resolved upstream; the value arrives on rs1_data_i.
  assign unused_rs1_field_s = ^bus.insn_i[19:15];

  assign accept_s    = bus.valid_i & (state_q == IDLE);
  assign last_exec_s = (state_q == EXEC) && (cnt_q == 4'd1);

  // Instruction decode: ALU control, operand B selection, rd and writeback.
  always_comb begin
    dec_legal_s = 1'b0;
    dec_ctrl_s  = CTRL_ADD;
    dec_b_s     = bus.rs2_data_i;
    dec_mul_s   = 1'b0;
    dec_we_s    = 1'b0;
    dec_rd_s    = bus.insn_i[11:7];
    case (opcode_s)
      OPC_OP: begin
        dec_we_s = 1'b1;
        if (funct7_s == 7'b0000000) begin
          dec_legal_s = 1'b1;
          case (funct3_s)
            3'b000:  dec_ctrl_s = 4'b0010;
            3'b001:  dec_ctrl_s = 4'b0001;
            3'b100:  dec_ctrl_s = 4'b1000;
            3'b111:  dec_ctrl_s = 4'b0000;
            default: dec_legal_s = 1'b0;
          endcase
        end else if ((funct7_s == 7'b0100000) && (funct3_s == 3'b000)) begin
          dec_legal_s = 1'b1;
          dec_ctrl_s  = 4'b0110;
        end else if ((funct7_s == 7'b0000001) && (funct3_s == 3'b000)) begin
          dec_legal_s = 1'b1;
          dec_ctrl_s  = 4'b1010;
          dec_mul_s   = 1'b1;
        end else begin
          dec_legal_s = 1'b0;
        end
      end
      OPC_OPIMM: begin
        dec_we_s = 1'b1;
        if (funct3_s == 3'b000) begin
          dec_legal_s = 1'b1;
          dec_b_s     = sext12(bus.insn_i[31:20]);
        end else if ((funct3_s == 3'b101) && (funct7_s == 7'b0100000)) begin
          dec_legal_s = 1'b1;
          dec_ctrl_s  = 4'b0101;
          dec_b_s     = {27'b0, bus.insn_i[24:20]};
        end else begin
          dec_legal_s = 1'b0;
        end
      end
      OPC_LOAD: begin
        dec_legal_s = (funct3_s == 3'b010);
        dec_b_s     = sext12(bus.insn_i[31:20]);
      end
      OPC_STORE: begin
        dec_legal_s = (funct3_s == 3'b010);
        dec_b_s     = sext12({bus.insn_i[31:25], bus.insn_i[11:7]});
        dec_rd_s    = 5'd0;
      end
      default: dec_legal_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: legal ops go through EXEC, illegal ones straight to RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = dec_legal_s ? EXEC : RESP;
        else          state_d = IDLE;
      end
      EXEC: begin
        if (last_exec_s) state_d = RESP;
        else             state_d = EXEC;
      end
      RESP: begin
        if (bus.res_ready_i) state_d = IDLE;
        else                 state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch decode on accept, count EXEC cycles, capture the result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= 4'd0;
      alu_ctrl_q <= CTRL_ADD;
      alu_a_q    <= 32'd0;
      alu_b_q    <= 32'd0;
      res_data_q <= 32'd0;
      res_rd_q   <= 5'd0;
      res_we_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            if (dec_legal_s) begin
              alu_ctrl_q <= dec_ctrl_s;
              alu_a_q    <= bus.rs1_data_i;
              alu_b_q    <= dec_b_s;
              cnt_q      <= dec_mul_s ? MUL_CNT : 4'd1;
              res_rd_q   <= dec_rd_s;
              res_we_q   <= dec_we_s;
              illegal_q  <= 1'b0;
            end else begin
              res_data_q <= 32'd0;
              res_rd_q   <= 5'd0;
              res_we_q   <= 1'b0;
              illegal_q  <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (last_exec_s) begin
            res_data_q <= bus.alu_result_i;
            alu_ctrl_q <= CTRL_ADD;
            alu_a_q    <= 32'd0;
            alu_b_q    <= 32'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ready_o     = (state_q == IDLE);
  assign bus.res_valid_o = (state_q == RESP);
  assign bus.alu_ctrl_o  = alu_ctrl_q;
  assign bus.alu_a_o     = alu_a_q;
  assign bus.alu_b_o     = alu_b_q;
  assign bus.res_data_o  = res_data_q;
  assign bus.res_rd_o    = res_rd_q;
  assign bus.res_we_o    = res_we_q;
  assign bus.illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, scoreboard of expected responses,
// one task per scenario.
module tb_alu_issue_ctrl;
  localparam int MUL_LAT = 3;
  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011, ST  = 7'b0100011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_if bus();
  alu_issue_ctrl #(.MUL_LAT(MUL_LAT)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [31:0] insn, rs1, rs2;
    logic [3:0]  ctrl;
    logic [31:0] b, data;
    logic [4:0]  rd;
    logic        we;
  } op_t;

  // Reference ALU driven by the controller's operands.
  always_comb begin
    case (bus.alu_ctrl_o)
      4'b0010: bus.alu_result_i = bus.alu_a_o + bus.alu_b_o;
      4'b0110: bus.alu_result_i = bus.alu_a_o - bus.alu_b_o;
      4'b0001: bus.alu_result_i = bus.alu_a_o << bus.alu_b_o[4:0];
      4'b1000: bus.alu_result_i = bus.alu_a_o ^ bus.alu_b_o;
      4'b0000: bus.alu_result_i = bus.alu_a_o & bus.alu_b_o;
      4'b0101: bus.alu_result_i = 32'($signed(bus.alu_a_o) >>> bus.alu_b_o[4:0]);
      4'b1010: bus.alu_result_i = 32'(bus.alu_a_o * bus.alu_b_o);
      default: bus.alu_result_i = 32'd0;
    endcase
  end

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single edge, then scramble the inputs.
  task automatic accept(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    bus.valid_i    = 1'b1;
    bus.insn_i     = insn;
    bus.rs1_data_i = rs1;
    bus.rs2_data_i = rs2;
    tick();
    bus.valid_i    = 1'b0;
    bus.insn_i     = $urandom;
    bus.rs1_data_i = $urandom;
    bus.rs2_data_i = $urandom;
  endtask

  // Called in cycle 1 after accept; returns the cycle res_valid_o was seen (bounded).
  task automatic wait_resp(output int cyc);
    cyc = 1;
    while (bus.res_valid_o !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
    n_cmp++; if (bus.res_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid_o); end
    n_cmp++; if (bus.alu_ctrl_o !== 4'b0010) begin n_err++; $display("FAIL reset_ctrl: got %b want 0010", bus.alu_ctrl_o); end
    n_cmp++; if ({bus.alu_a_o, bus.alu_b_o} !== 64'd0) begin n_err++; $display("FAIL reset_alu_ab: got %h %h want 0 0", bus.alu_a_o, bus.alu_b_o); end
    n_cmp++;
    if ({bus.res_data_o, bus.res_rd_o, bus.res_we_o, bus.illegal_o} !== 39'd0) begin
      n_err++; $display("FAIL reset_res: got data=%h rd=%0d we=%b ill=%b want all 0",
                        bus.res_data_o, bus.res_rd_o, bus.res_we_o, bus.illegal_o);
    end
  endtask

  task automatic test_alu_ops();
    op_t  tbl[10];
    exp_t e;
    int   cyc;
    tbl[0] = '{r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, OP), 32'd5, 32'd7, 4'b0010, 32'd7, 32'd12, 5'd3, 1'b1};
    tbl[1] = '{r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd4, OP), 32'd3, 32'd5, 4'b0110, 32'd5, 32'hFFFFFFFE, 5'd4, 1'b1};
    tbl[2] = '{r_type(7'h00, 5'd2, 5'd1, 3'b001, 5'd6, OP), 32'd1, 32'd33, 4'b0001, 32'd33, 32'd2, 5'd6, 1'b1};
    tbl[3] = '{r_type(7'h00, 5'd2, 5'd1, 3'b100, 5'd7, OP), 32'hF0F0F0F0, 32'h0FF00FF0, 4'b1000, 32'h0FF00FF0, 32'hFF00FF00, 5'd7, 1'b1};
    tbl[4] = '{r_type(7'h00, 5'd2, 5'd1, 3'b111, 5'd8, OP), 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0000, 32'h0FF00FF0, 32'h00F000F0, 5'd8, 1'b1};
    tbl[5] = '{i_type(12'hFFF, 5'd1, 3'b000, 5'd9, OPI), 32'd0, 32'h0000DEAD, 4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 1'b1};
    tbl[6] = '{i_type({7'b0100000, 5'd4}, 5'd6, 3'b101, 5'd5, OPI), 32'h80000000, 32'd99, 4'b0101, 32'd4, 32'hF8000000, 5'd5, 1'b1};
    tbl[7] = '{i_type(12'd16, 5'd2, 3'b010, 5'd10, LD), 32'h00001000, 32'd1, 4'b0010, 32'd16, 32'h00001010, 5'd10, 1'b0};
    tbl[8] = '{s_type(12'hFF8, 5'd3, 5'd2, 3'b010, ST), 32'h00000100, 32'h55, 4'b0010, 32'hFFFFFFF8, 32'h000000F8, 5'd0, 1'b0};
    tbl[9] = '{r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd15, OP), 32'hFFFFFFFF, 32'd2, 4'b0010, 32'd2, 32'd1, 5'd15, 1'b1};
    bus.res_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sb_q.push_back('{tbl[i].data, tbl[i].rd, tbl[i].we, 1'b0, 2});
      accept(tbl[i].insn, tbl[i].rs1, tbl[i].rs2);
      n_cmp++;
      if ({bus.alu_ctrl_o, bus.alu_a_o, bus.alu_b_o, bus.ready_o} !== {tbl[i].ctrl, tbl[i].rs1, tbl[i].b, 1'b0}) begin
        n_err++; $display("FAIL op%0d_exec: got ctrl=%b a=%h b=%h rdy=%b want ctrl=%b a=%h b=%h rdy=0",
                          i, bus.alu_ctrl_o, bus.alu_a_o, bus.alu_b_o, bus.ready_o, tbl[i].ctrl, tbl[i].rs1, tbl[i].b);
      end
      wait_resp(cyc);
      e = sb_q.pop_front();
      n_cmp++;
      if (cyc != e.lat) begin n_err++; $display("FAIL op%0d_latency: got %0d want %0d", i, cyc, e.lat); end
      n_cmp++;
      if ({bus.res_data_o, bus.res_rd_o, bus.res_we_o, bus.illegal_o} !== {e.data, e.rd, e.we, e.ill}) begin
        n_err++; $display("FAIL op%0d_result: got data=%h rd=%0d we=%b ill=%b want data=%h rd=%0d we=%b ill=%b",
                          i, bus.res_data_o, bus.res_rd_o, bus.res_we_o, bus.illegal_o, e.data, e.rd, e.we, e.ill);
      end
      tick();
      n_cmp++;
      if ({bus.res_valid_o, bus.ready_o} !== 2'b01) begin
        n_err++; $display("FAIL op%0d_release: got valid=%b ready=%b want 0 1", i, bus.res_valid_o, bus.ready_o);
      end
    end
  endtask

  task automatic test_mul();
    exp_t e;
    bus.res_ready_i = 1'b1;
    sb_q.push_back('{32'hFFFFFFF4, 5'd11, 1'b1, 1'b0, 1 + MUL_LAT});
    accept(r_type(7'h01, 5'd2, 5'd1, 3'b000, 5'd11, OP), 32'hFFFFFFFD, 32'd4);
    for (int c = 1; c <= MUL_LAT; c++) begin
      n_cmp++;
      if ({bus.alu_ctrl_o, bus.alu_a_o, bus.alu_b_o, bus.ready_o, bus.res_valid_o} !==
          {4'b1010, 32'hFFFFFFFD, 32'd4, 1'b0, 1'b0}) begin
        n_err++; $display("FAIL mul_exec_c%0d: got ctrl=%b a=%h b=%h rdy=%b vld=%b want 1010 fffffffd 00000004 0 0",
                          c, bus.alu_ctrl_o, bus.alu_a_o, bus.alu_b_o, bus.ready_o, bus.res_valid_o);
      end
      tick();
    end
    e = sb_q.pop_front();
    n_cmp++;
    if ({bus.res_valid_o, bus.ready_o, bus.res_data_o, bus.res_rd_o, bus.res_we_o} !== {1'b1, 1'b0, e.data, e.rd, e.we}) begin
      n_err++; $display("FAIL mul_result_c%0d: got vld=%b rdy=%b data=%h rd=%0d we=%b want 1 0 %h %0d %b",
                        e.lat, bus.res_valid_o, bus.ready_o, bus.res_data_o, bus.res_rd_o, bus.res_we_o, e.data, e.rd, e.we);
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [31:0] bad[4];
    exp_t e;
    int   cyc;
    bad[0] = 32'h0000007F;
    bad[1] = r_type(7'h02, 5'd2, 5'd1, 3'b000, 5'd5, OP);
    bad[2] = i_type(12'd3, 5'd1, 3'b001, 5'd9, OPI);
    bad[3] = i_type(12'd4, 5'd1, 3'b000, 5'd6, LD);
    bus.res_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{32'd0, 5'd0, 1'b0, 1'b1, 1});
      accept(bad[i], 32'h12345678, 32'h9ABCDEF0);
      n_cmp++;
      if ({bus.alu_ctrl_o, bus.alu_a_o} !== {4'b0010, 32'd0}) begin
        n_err++; $display("FAIL ill%0d_no_exec: got ctrl=%b a=%h want 0010 0", i, bus.alu_ctrl_o, bus.alu_a_o);
      end
      wait_resp(cyc);
      e = sb_q.pop_front();
      n_cmp++;
      if (cyc != e.lat) begin n_err++; $display("FAIL ill%0d_latency: got %0d want %0d", i, cyc, e.lat); end
      n_cmp++;
      if ({bus.illegal_o, bus.res_data_o, bus.res_rd_o, bus.res_we_o} !== {e.ill, e.data, e.rd, e.we}) begin
        n_err++; $display("FAIL ill%0d_result: got ill=%b data=%h rd=%0d we=%b want 1 0 0 0",
                          i, bus.illegal_o, bus.res_data_o, bus.res_rd_o, bus.res_we_o);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   cyc;
    bus.res_ready_i = 1'b0;
    sb_q.push_back('{32'h00000030, 5'd12, 1'b1, 1'b0, 2});
    accept(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd12, OP), 32'h10, 32'h20);
    wait_resp(cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (cyc != e.lat) begin n_err++; $display("FAIL bp_latency: got %0d want %0d", cyc, e.lat); end
    for (int c = 0; c < 5; c++) begin
      bus.valid_i    = 1'b1;
      bus.insn_i     = r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd20, OP);
      bus.rs1_data_i = 32'd100;
      bus.rs2_data_i = 32'd1;
      tick();
      n_cmp++;
      if ({bus.res_valid_o, bus.ready_o, bus.res_data_o, bus.res_rd_o, bus.res_we_o, bus.illegal_o} !==
          {1'b1, 1'b0, e.data, e.rd, e.we, e.ill}) begin
        n_err++; $display("FAIL bp_hold_c%0d: got vld=%b rdy=%b data=%h rd=%0d we=%b ill=%b want 1 0 %h %0d %b %b",
                          c, bus.res_valid_o, bus.ready_o, bus.res_data_o, bus.res_rd_o, bus.res_we_o, bus.illegal_o,
                          e.data, e.rd, e.we, e.ill);
      end
    end
    bus.valid_i     = 1'b0;
    bus.res_ready_i = 1'b1;
    tick();
    n_cmp++;
    if ({bus.res_valid_o, bus.ready_o} !== 2'b01) begin
      n_err++; $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", bus.res_valid_o, bus.ready_o);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({bus.res_valid_o, bus.alu_ctrl_o} !== {1'b0, 4'b0010}) begin
        n_err++; $display("FAIL bp_stalled_not_taken_c%0d: got vld=%b ctrl=%b want 0 0010", c, bus.res_valid_o, bus.alu_ctrl_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.res_ready_i = 1'b1;
    accept(r_type(7'h01, 5'd2, 5'd1, 3'b000, 5'd11, OP), 32'd6, 32'd7);
    n_cmp++;
    if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL rstmid_in_exec: got rdy=%b want 0", bus.ready_o); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.ready_o, bus.res_valid_o, bus.alu_ctrl_o, bus.alu_a_o} !== {1'b1, 1'b0, 4'b0010, 32'd0}) begin
      n_err++; $display("FAIL rstmid_async: got rdy=%b vld=%b ctrl=%b a=%h want 1 0 0010 0",
                        bus.ready_o, bus.res_valid_o, bus.alu_ctrl_o, bus.alu_a_o);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if ({bus.res_valid_o, bus.ready_o} !== 2'b01) begin
        n_err++; $display("FAIL rstmid_dropped_c%0d: got vld=%b rdy=%b want 0 1", c, bus.res_valid_o, bus.ready_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    bus.res_ready_i = 1'b1;
    sb_q.push_back('{32'd3, 5'd13, 1'b1, 1'b0, 2});
    sb_q.push_back('{32'd6, 5'd14, 1'b1, 1'b0, 2});
    accept(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd13, OP), 32'd1, 32'd2);
    wait_resp(cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if ({bus.res_data_o, bus.res_rd_o} !== {e.data, e.rd} || cyc != e.lat) begin
      n_err++; $display("FAIL b2b_first: got data=%h rd=%0d lat=%0d want %h %0d %0d", bus.res_data_o, bus.res_rd_o, cyc, e.data, e.rd, e.lat);
    end
    bus.valid_i    = 1'b1;
    bus.insn_i     = r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd14, OP);
    bus.rs1_data_i = 32'd10;
    bus.rs2_data_i = 32'd4;
    tick();
    n_cmp++;
    if ({bus.res_valid_o, bus.ready_o} !== 2'b01) begin
      n_err++; $display("FAIL b2b_gap: got vld=%b rdy=%b want 0 1", bus.res_valid_o, bus.ready_o);
    end
    tick();
    bus.valid_i = 1'b0;
    n_cmp++;
    if ({bus.ready_o, bus.alu_ctrl_o, bus.alu_a_o, bus.alu_b_o} !== {1'b0, 4'b0110, 32'd10, 32'd4}) begin
      n_err++; $display("FAIL b2b_second_exec: got rdy=%b ctrl=%b a=%h b=%h want 0 0110 a 4",
                        bus.ready_o, bus.alu_ctrl_o, bus.alu_a_o, bus.alu_b_o);
    end
    wait_resp(cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if ({bus.res_data_o, bus.res_rd_o, bus.res_we_o} !== {e.data, e.rd, e.we} || cyc != e.lat) begin
      n_err++; $display("FAIL b2b_second: got data=%h rd=%0d we=%b lat=%0d want %h %0d %b %0d",
                        bus.res_data_o, bus.res_rd_o, bus.res_we_o, cyc, e.data, e.rd, e.we, e.lat);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_i     = 1'b0;
    bus.insn_i      = 32'd0;
    bus.rs1_data_i  = 32'd0;
    bus.rs2_data_i  = 32'd0;
    bus.res_ready_i = 1'b1;
    rst             = 1'b1;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_alu_ops();
    test_mul();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
